trial_div: RTL and testbench



---
 rtl/trial_div_pkg.sv | 13 +
 rtl/trial_div.sv | 183 ++++++++++++++++++
 tb/tb_trial_div.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trial_div_pkg.sv
// Shared types for the trial-division primality tester.
// Optional trial counter enabled by TRIAL_DIV_STATS_EN.
package trial_div_pkg;

    localparam int TRIALS_W = 8;

    typedef logic [TRIALS_W-1:0] trials_t;

    function automatic trials_t sat_inc(input trials_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/trial_div.sv
// Primality tester driving an external divmod with odd trial divisors.
// Define TRIAL_DIV_STATS_EN to add the saturating trials output.
module trial_div
    import trial_div_pkg::*;
#(
    parameter int WIDTH_LOG = 4,
    localparam int WIDTH = 1 << WIDTH_LOG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] n,
    output logic             ready,
    output logic             error,
    output logic             is_prime,
    output logic [WIDTH-1:0] factor,
`ifdef TRIAL_DIV_STATS_EN
    output logic [TRIALS_W-1:0] trials,
`endif
    output logic             dm_go,
    output logic [WIDTH-1:0] dm_a,
    output logic [WIDTH-1:0] dm_b,
    input  logic             dm_ready,
    input  logic             dm_error,
    input  logic [WIDTH-1:0] dm_div,
    input  logic [WIDTH-1:0] dm_mod
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CLASSIFY = 2'd1;
    localparam logic [1:0] S_ISSUE    = 2'd2;
    localparam logic [1:0] S_WAIT     = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = S_IDLE,
        CLASSIFY = S_CLASSIFY,
        ISSUE    = S_ISSUE,
        WAIT     = S_WAIT
    } state_t;

    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

    state_t           state, state_nxt;
    logic             go_prev;
    logic [WIDTH-1:0] n_q, n_nxt;
    logic [WIDTH-1:0] d, d_nxt;
    logic             guard, guard_nxt;
    logic             ready_nxt, error_nxt, prime_nxt, go_nxt;
    logic [WIDTH-1:0] factor_nxt, a_nxt, b_nxt;
`ifdef TRIAL_DIV_STATS_EN
    trials_t          trials_nxt;
`endif

    always_comb begin
        state_nxt  = state;
        n_nxt      = n_q;
        d_nxt      = d;
        guard_nxt  = 1'b0;
        ready_nxt  = ready;
        error_nxt  = error;
        prime_nxt  = is_prime;
        factor_nxt = factor;
        go_nxt     = 1'b0;
        a_nxt      = dm_a;
        b_nxt      = dm_b;
`ifdef TRIAL_DIV_STATS_EN
        trials_nxt = trials;
`endif
        unique case (state)
            IDLE: begin
                if (go && !go_prev) begin
                    n_nxt     = n;
                    error_nxt = 1'b0;
                    ready_nxt = 1'b0;
                    guard_nxt = 1'b1;
                    state_nxt = CLASSIFY;
`ifdef TRIAL_DIV_STATS_EN
                    trials_nxt = '0;
`endif
                end
            end
            CLASSIFY: begin
                // Guard cycle first, so trivial results land two cycles after go.
                if (!guard) begin
                    if (n_q < TWO) begin
                        prime_nxt  = 1'b0;
                        factor_nxt = '0;
                        ready_nxt  = 1'b1;
                        state_nxt  = IDLE;
                    end else if (n_q == TWO || n_q == THREE) begin
                        prime_nxt  = 1'b1;
                        factor_nxt = n_q;
                        ready_nxt  = 1'b1;
                        state_nxt  = IDLE;
                    end else if (!n_q[0]) begin
                        prime_nxt  = 1'b0;
                        factor_nxt = TWO;
                        ready_nxt  = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        d_nxt     = THREE;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                a_nxt     = n_q;
                b_nxt     = d;
                go_nxt    = 1'b1;
                guard_nxt = 1'b1;
                state_nxt = WAIT;
`ifdef TRIAL_DIV_STATS_EN
                trials_nxt = sat_inc(trials);
`endif
            end
            WAIT: begin
                // divmod's ready is stale in the first cycle after the go pulse.
                if (!guard && dm_ready) begin
                    if (dm_error) begin
                        error_nxt  = 1'b1;
                        prime_nxt  = 1'b0;
                        factor_nxt = '0;
                        ready_nxt  = 1'b1;
                        state_nxt  = IDLE;
                    end else if (dm_mod == '0) begin
                        prime_nxt  = 1'b0;
                        factor_nxt = d;
                        ready_nxt  = 1'b1;
                        state_nxt  = IDLE;
                    end else if (dm_div < d) begin
                        prime_nxt  = 1'b1;
                        factor_nxt = n_q;
                        ready_nxt  = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        d_nxt     = d + TWO;
                        state_nxt = ISSUE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            go_prev  <= 1'b0;
            n_q      <= '0;
            d        <= '0;
            guard    <= 1'b0;
            ready    <= 1'b1;
            error    <= 1'b0;
            is_prime <= 1'b0;
            factor   <= '0;
            dm_go    <= 1'b0;
            dm_a     <= '0;
            dm_b     <= '0;
`ifdef TRIAL_DIV_STATS_EN
            trials   <= '0;
`endif
        end else begin
            if (state == ISSUE) assert (d[0]);
            if (dm_go) assert (dm_b != '0);
            state    <= state_nxt;
            go_prev  <= go;
            n_q      <= n_nxt;
            d        <= d_nxt;
            guard    <= guard_nxt;
            ready    <= ready_nxt;
            error    <= error_nxt;
            is_prime <= prime_nxt;
            factor   <= factor_nxt;
            dm_go    <= go_nxt;
            dm_a     <= a_nxt;
            dm_b     <= b_nxt;
`ifdef TRIAL_DIV_STATS_EN
            trials   <= trials_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_trial_div.sv
// Bench for trial_div with a behavioural divmod peer.
// Results are checked through a queue of expected outcomes.
module tb_trial_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [15:0] n = '0;
    logic        ready, error, is_prime, dm_go;
    logic [15:0] factor, dm_a, dm_b;
    logic        dm_ready, dm_error;
    logic [15:0] dm_div, dm_mod;
`ifdef TRIAL_DIV_STATS_EN
    logic [7:0]  trials;
`endif

    typedef struct packed {
        logic        p;
        logic [15:0] f;
        logic        e;
    } res_t;

    res_t        sb[$];
    logic [15:0] dlog[$];
    int          pass_cnt = 0;
    int          total = 0;
    bit          force_err = 1'b0;

    logic        m_gp;
    int          m_cnt;
    logic [15:0] m_a, m_b;

    trial_div #(.WIDTH_LOG(4)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .n(n),
        .ready(ready), .error(error), .is_prime(is_prime),
        .factor(factor),
`ifdef TRIAL_DIV_STATS_EN
        .trials(trials),
`endif
        .dm_go(dm_go), .dm_a(dm_a), .dm_b(dm_b),
        .dm_ready(dm_ready), .dm_error(dm_error),
        .dm_div(dm_div), .dm_mod(dm_mod)
    );

    always #5 clk = ~clk;

    // divmod model: starts on a dm_go rising edge, busy 1..4 cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_ready <= 1'b1;
            dm_error <= 1'b0;
            dm_div   <= '0;
            dm_mod   <= '0;
            m_gp     <= 1'b0;
            m_cnt    <= 0;
            m_a      <= '0;
            m_b      <= '0;
        end else begin
            m_gp <= dm_go;
            if (dm_go && !m_gp) begin
                dm_ready <= 1'b0;
                m_a      <= dm_a;
                m_b      <= dm_b;
                m_cnt    <= int'($urandom_range(1, 4));
                dlog.push_back(dm_b);
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    dm_ready <= 1'b1;
                    dm_error <= force_err || (m_b == 0);
                    dm_div   <= (m_b == 0) ? 16'hFFFF : m_a / m_b;
                    dm_mod   <= (m_b == 0) ? m_a : m_a % m_b;
                end
            end
        end
    end

    task automatic start_run(input logic [15:0] v);
        @(negedge clk);
        go = 1'b1;
        n = v;
        dlog.delete();
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_ready(output int lowc);
        lowc = 0;
        while (!ready && lowc < 5000) begin
            lowc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({ready, error, is_prime, factor, dm_go, dm_a, dm_b} !==
            {1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0}) begin
            $display("FAIL reset: got r=%0b e=%0b p=%0b f=%0d g=%0b a=%0d b=%0d want 1 0 0 0 0 0 0",
                     ready, error, is_prime, factor, dm_go, dm_a, dm_b);
        end else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_trivial;
        logic [15:0] vals[4] = '{16'd0, 16'd1, 16'd2, 16'd4};
        res_t        exps[4] = '{'{1'b0, 16'd0, 1'b0}, '{1'b0, 16'd0, 1'b0},
                                 '{1'b1, 16'd2, 1'b0}, '{1'b0, 16'd2, 1'b0}};
        res_t        e;
        int          lowc;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(exps[i]);
            start_run(vals[i]);
            wait_ready(lowc);
            e = sb.pop_front();
            total++;
            if ({is_prime, factor, error} !== e) begin
                $display("FAIL trivial n=%0d: got p=%0b f=%0d e=%0b want p=%0b f=%0d e=%0b",
                         vals[i], is_prime, factor, error, e.p, e.f, e.e);
            end else pass_cnt++;
            total++;
            if (lowc !== 2) begin
                $display("FAIL trivial_ready_low n=%0d: got %0d cycles want 2", vals[i], lowc);
            end else pass_cnt++;
            total++;
            if (dlog.size() !== 0) begin
                $display("FAIL trivial_no_dm_go n=%0d: got %0d pulses want 0", vals[i], dlog.size());
            end else pass_cnt++;
        end
    endtask

    task automatic test_trials;
        logic [15:0] vals[4] = '{16'd97, 16'd91, 16'd65535, 16'd65521};
        res_t        exps[4] = '{'{1'b1, 16'd97, 1'b0}, '{1'b0, 16'd7, 1'b0},
                                 '{1'b0, 16'd3, 1'b0}, '{1'b1, 16'd65521, 1'b0}};
        int          cnts[4] = '{5, 3, 1, 128};
        logic [15:0] last[4] = '{16'd11, 16'd7, 16'd3, 16'd257};
        res_t        e;
        int          lowc;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(exps[i]);
            start_run(vals[i]);
            wait_ready(lowc);
            e = sb.pop_front();
            total++;
            if (lowc >= 5000 || {is_prime, factor, error} !== e) begin
                $display("FAIL trial n=%0d: got p=%0b f=%0d e=%0b r=%0b want p=%0b f=%0d e=%0b r=1",
                         vals[i], is_prime, factor, error, ready, e.p, e.f, e.e);
            end else pass_cnt++;
            total++;
            if (dlog.size() !== cnts[i] || dlog[dlog.size()-1] !== last[i]) begin
                $display("FAIL trial_count n=%0d: got %0d pulses last d=%0d want %0d last d=%0d",
                         vals[i], dlog.size(), dlog[dlog.size()-1], cnts[i], last[i]);
            end else pass_cnt++;
`ifdef TRIAL_DIV_STATS_EN
            total++;
            if (trials !== 8'(cnts[i] > 255 ? 255 : cnts[i])) begin
                $display("FAIL trials n=%0d: got %0d want %0d", vals[i], trials, cnts[i]);
            end else pass_cnt++;
`endif
            if (i == 0) begin
                total++;
                if (dlog.size() != 5 || dlog[0] !== 16'd3 || dlog[1] !== 16'd5 ||
                    dlog[2] !== 16'd7 || dlog[3] !== 16'd9 || dlog[4] !== 16'd11) begin
                    $display("FAIL d_sequence_97: got size %0d want d=3,5,7,9,11", dlog.size());
                end else pass_cnt++;
            end
        end
    endtask

    task automatic test_busy_go;
        res_t e;
        int   lowc;
        sb.push_back('{1'b0, 16'd7, 1'b0});
        start_run(16'd91);
        repeat (3) @(negedge clk);
        go = 1'b1;
        n = 16'd4;
        @(negedge clk);
        go = 1'b0;
        wait_ready(lowc);
        e = sb.pop_front();
        total++;
        if ({is_prime, factor, error} !== e || dlog.size() !== 3) begin
            $display("FAIL busy_go: got p=%0b f=%0d e=%0b pulses=%0d want p=0 f=7 e=0 pulses=3",
                     is_prime, factor, error, dlog.size());
        end else pass_cnt++;
        repeat (5) @(negedge clk);
        total++;
        if (ready !== 1'b1 || factor !== 16'd7 || dlog.size() !== 3) begin
            $display("FAIL busy_go_hold: got r=%0b f=%0d pulses=%0d want r=1 f=7 pulses=3",
                     ready, factor, dlog.size());
        end else pass_cnt++;
    endtask

    task automatic test_error;
        res_t e;
        int   lowc;
        force_err = 1'b1;
        sb.push_back('{1'b0, 16'd0, 1'b1});
        start_run(16'd25);
        wait_ready(lowc);
        e = sb.pop_front();
        total++;
        if ({is_prime, factor, error} !== e) begin
            $display("FAIL dm_error: got p=%0b f=%0d e=%0b want p=0 f=0 e=1",
                     is_prime, factor, error);
        end else pass_cnt++;
        force_err = 1'b0;
        sb.push_back('{1'b0, 16'd3, 1'b0});
        start_run(16'd9);
        wait_ready(lowc);
        e = sb.pop_front();
        total++;
        if ({is_prime, factor, error} !== e) begin
            $display("FAIL error_cleared: got p=%0b f=%0d e=%0b want p=0 f=3 e=0",
                     is_prime, factor, error);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int k = 0;
        start_run(16'd65521);
        while (dlog.size() < 2 && k < 200) begin
            k++;
            @(negedge clk);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({ready, error, is_prime, factor, dm_go, dm_a, dm_b} !==
            {1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0}) begin
            $display("FAIL reset_mid: got r=%0b e=%0b p=%0b f=%0d g=%0b a=%0d b=%0d want 1 0 0 0 0 0 0",
                     ready, error, is_prime, factor, dm_go, dm_a, dm_b);
        end else pass_cnt++;
`ifdef TRIAL_DIV_STATS_EN
        total++;
        if (trials !== 8'd0) begin
            $display("FAIL reset_mid_trials: got %0d want 0", trials);
        end else pass_cnt++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        dlog.delete();
        repeat (6) @(negedge clk);
        total++;
        if (ready !== 1'b1 || dlog.size() !== 0) begin
            $display("FAIL reset_mid_idle: got r=%0b pulses=%0d want r=1 pulses=0",
                     ready, dlog.size());
        end else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_trivial();
        test_trials();
        test_busy_go();
        test_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
